// File: rtl/mul_restoring_pkg.sv
// Shared widths and constants for the shift-and-add multiplier.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package mul_restoring_pkg;

  localparam int OPW  = 16;          // operand width
  localparam int RESW = 32;          // result width
  localparam int ITER = 16;          // one iteration per multiplier bit
  localparam int CNTW = 5;           // wide enough to hold ITER itself
  localparam int ACCW = RESW + 1;    // {carry, hi, lo}

  // Last iteration index; the edge that sees it also completes the operation.
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(ITER - 1);

  typedef logic [ACCW-1:0] acc_t;
  typedef logic [OPW-1:0]  opnd_t;

endpackage

// File: rtl/mul_restoring_step.sv
// One conditional-add-and-shift iteration of the multiplier datapath.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module mul_step
  import mul_restoring_pkg::*;
(
  input  logic [ACCW-1:0] acc,
  input  logic [OPW-1:0]  reg_a,
  output logic [ACCW-1:0] acc_nxt
);

  logic [OPW:0] sum;

  // The carry bit is always cleared by the shift below, so its old value
  // has no effect on the next accumulator.
  logic unused_carry;
  assign unused_carry = acc[ACCW-1];

  // Add the multiplicand into the high half when the current multiplier bit
  // is set, then shift {sum, lo} right by one so the next bit lands in acc[0].
  always_comb begin
    sum = {1'b0, acc[RESW-1:OPW]};
    if (acc[0]) begin
      sum = {1'b0, acc[RESW-1:OPW]} + {1'b0, reg_a};
    end
    acc_nxt = {1'b0, sum, acc[OPW-1:1]};
  end

endmodule

// File: rtl/mul_restoring.sv
// Sequential unsigned multiply-add: p = a*b + c, one multiplier bit per cycle.
// Latency: start at edge N gives ready and a valid p after edge N+16.
// Backpressure: none; a new start aborts any operation in flight and reloads.
module mul_restoring
  import mul_restoring_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  input  logic [OPW-1:0]  c,
  input  logic            start,
  output logic [RESW-1:0] p,
  output logic            busy,
  output logic            ready,
  output logic [CNTW-1:0] count
);

  logic [ACCW-1:0] acc;
  logic [ACCW-1:0] acc_nxt;
  logic [OPW-1:0]  reg_a;

  mul_step u_step (
    .acc     (acc),
    .reg_a   (reg_a),
    .acc_nxt (acc_nxt)
  );

  // The low half of the accumulator starts as the multiplier and is consumed
  // bit by bit; after ITER shifts the full accumulator holds a*b + c.
  assign p = acc[RESW-1:0];

  // Operand load on start (highest priority), otherwise iterate while busy;
  // idle cycles keep everything, so ready/p/count hold after completion.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      acc   <= '0;
      reg_a <= '0;
      count <= '0;
      busy  <= 1'b0;
      ready <= 1'b0;
    end else if (start) begin
      reg_a <= a;
      acc   <= {1'b0, c, b};
      count <= '0;
      busy  <= 1'b1;
      ready <= 1'b0;
    end else if (busy) begin
      acc   <= acc_nxt;
      count <= count + 1'b1;
      if (count == CNT_LAST) begin
        busy  <= 1'b0;
        ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mul_restoring.sv
// Self-checking bench for mul_restoring against an arithmetic reference.
// Latency: checks the exact 16-cycle start-to-ready timing.
// Backpressure: exercises restart-while-busy and held start.
module tb_mul_restoring;

  logic        clk;
  logic        clr;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] c;
  logic        start;
  logic [31:0] p;
  logic        busy;
  logic        ready;
  logic [4:0]  count;

  int n_checks;
  int n_errors;

  mul_restoring dut (
    .clk   (clk),
    .clr   (clr),
    .a     (a),
    .b     (b),
    .c     (c),
    .start (start),
    .p     (p),
    .busy  (busy),
    .ready (ready),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain wide arithmetic.
  function automatic logic [31:0] ref_mac(input logic [15:0] x, input logic [15:0] y,
                                          input logic [15:0] z);
    logic [63:0] r;
    r = 64'(x) * 64'(y) + 64'(z);
    return r[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    a = 16'($urandom);
    b = 16'($urandom);
    c = 16'($urandom);
  endtask

  // Issue one start and follow the operation edge by edge to completion.
  task automatic run_op(input logic [15:0] opa, input logic [15:0] opb,
                        input logic [15:0] opc, input bit scramble, input string tag);
    logic [31:0] exp_p;
    logic [6:0]  st;
    logic [31:0] q;
    logic [31:0] r;
    exp_p = ref_mac(opa, opb, opc);
    a = opa; b = opb; c = opc; start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    st = {busy, ready, count};
    if (st !== {1'b1, 1'b0, 5'd0}) begin
      n_errors++;
      $display("FAIL %s_load: busy/ready/count=%b required %b", tag, st, {1'b1, 1'b0, 5'd0});
    end
    for (int k = 1; k < 16; k++) begin
      if (scramble) scramble_inputs();
      step();
      n_checks++;
      st = {busy, ready, count};
      if (st !== {1'b1, 1'b0, 5'(k)}) begin
        n_errors++;
        $display("FAIL %s_iter%0d: busy/ready/count=%b required %b", tag, k, st,
                 {1'b1, 1'b0, 5'(k)});
      end
    end
    if (scramble) scramble_inputs();
    step();
    n_checks++;
    st = {busy, ready, count};
    if (st !== {1'b0, 1'b1, 5'd16}) begin
      n_errors++;
      $display("FAIL %s_done: busy/ready/count=%b required %b", tag, st, {1'b0, 1'b1, 5'd16});
    end
    n_checks++;
    if (p !== exp_p) begin
      n_errors++;
      $display("FAIL %s_p: a=%h b=%h c=%h p=%h required %h", tag, opa, opb, opc, p, exp_p);
    end
    if (opc < opb) begin
      q = p / 32'(opb);
      r = p % 32'(opb);
      n_checks++;
      if (q !== 32'(opa) || r !== 32'(opc)) begin
        n_errors++;
        $display("FAIL %s_divcheck: q=%h r=%h required q=%h r=%h", tag, q, r, opa, opc);
      end
    end
  endtask

  task automatic check_idle_zero(input string tag);
    n_checks++;
    if ({busy, ready, count, p} !== 39'd0) begin
      n_errors++;
      $display("FAIL %s: busy=%b ready=%b count=%0d p=%h required all zero", tag, busy, ready,
               count, p);
    end
  endtask

  task automatic test_reset();
    clr = 1'b0; start = 1'b0; a = '0; b = '0; c = '0;
    #2 clr = 1'b1;
    #1 check_idle_zero("reset_async");
    step();
    step();
    check_idle_zero("reset_held");
    clr = 1'b0;
    step();
    step();
    check_idle_zero("reset_idle_after");
  endtask

  task automatic test_basic();
    logic [31:0] held_p;
    run_op(16'd3, 16'd5, 16'd2, 1'b0, "basic");
    n_checks++;
    if (p !== 32'd17) begin
      n_errors++;
      $display("FAIL basic_value: p=%0d required 17", p);
    end
    held_p = ref_mac(16'd3, 16'd5, 16'd2);
    for (int i = 0; i < 4; i++) begin
      scramble_inputs();
      step();
      n_checks++;
      if ({busy, ready, count, p} !== {1'b0, 1'b1, 5'd16, held_p}) begin
        n_errors++;
        $display("FAIL basic_hold%0d: busy=%b ready=%b count=%0d p=%h required 0 1 16 %h",
                 i, busy, ready, count, p, held_p);
      end
    end
  endtask

  task automatic test_max();
    run_op(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, "max");
    n_checks++;
    if (p !== 32'hFFFF0000) begin
      n_errors++;
      $display("FAIL max_value: p=%h required ffff0000", p);
    end
  endtask

  task automatic test_zero();
    run_op(16'h0000, 16'h1234, 16'h00AB, 1'b1, "zero");
    n_checks++;
    if (p !== 32'h000000AB) begin
      n_errors++;
      $display("FAIL zero_value: p=%h required 000000ab", p);
    end
  endtask

  task automatic test_restart();
    a = 16'd7; b = 16'd9; c = 16'd0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    n_checks++;
    if (count !== 5'd5 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL restart_mid: count=%0d busy=%b required 5 1", count, busy);
    end
    run_op(16'd2, 16'd3, 16'd1, 1'b1, "restart");
    n_checks++;
    if (p !== 32'd7) begin
      n_errors++;
      $display("FAIL restart_value: p=%0d required 7", p);
    end
  endtask

  task automatic test_held_start();
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      scramble_inputs();
      step();
      n_checks++;
      if ({busy, ready, count} !== {1'b1, 1'b0, 5'd0}) begin
        n_errors++;
        $display("FAIL held_start%0d: busy/ready/count=%b required 10_00000", i,
                 {busy, ready, count});
      end
    end
    run_op(16'hBEEF, 16'h0102, 16'h0033, 1'b1, "held");
  endtask

  task automatic test_mid_reset();
    a = 16'd100; b = 16'd200; c = 16'd0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    #2 clr = 1'b1;
    #1 check_idle_zero("midreset_async");
    step();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      scramble_inputs();
      step();
      check_idle_zero("midreset_idle");
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    run_op(16'd100, 16'd200, 16'd5, 1'b0, "post_reset_start");
  endtask

  task automatic test_random();
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] rc;
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      if (n % 50 == 0) rb = 16'hFFFF;
      repeat ($urandom_range(0, 3)) begin
        scramble_inputs();
        step();
      end
      run_op(ra, rb, rc, 1'b1, "random");
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_restart();
    test_held_start();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
